// File: rtl/flappy_pkg.sv
// Shared constants for the flappy button conditioner: channel FSM encodings,
// button indices and default timing.
package flappy_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_PRESS_CHK = 2'd1;
  localparam logic [1:0] ST_HELD      = 2'd2;
  localparam logic [1:0] ST_REL_CHK   = 2'd3;

  localparam int BTN_UP   = 32'd0;
  localparam int BTN_DOWN = 32'd1;

  localparam int DEF_N_BTN           = 32'd2;
  localparam int DEF_SYNC_STAGES     = 32'd2;
  localparam int DEF_DEBOUNCE_CYCLES = 32'd50000;
  localparam int DEF_CNT_W           = 32'd16;
  localparam int DEF_REPEAT_DELAY    = 32'd25000000;
  localparam int DEF_REPEAT_PERIOD   = 32'd5000000;

endpackage

// File: rtl/flappy_debounce_ch.sv
// One button channel: synchroniser, 4-state debounce FSM and counters.
// FLAPPY_AUTOREPEAT_EN adds a repeat counter that re-pulses press while held.
module flappy_debounce_ch
  import flappy_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
`ifdef FLAPPY_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic din,
  output logic level,
  output logic press,
  output logic rel
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [SYNC_STAGES-1:0] sync_r;
  logic [1:0]             state_r, state_s;
  logic [CNT_W-1:0]       cnt_r, cnt_s;
  logic                   level_r, level_s;
  logic                   press_r, press_s;
  logic                   rel_r, rel_s;
  logic                   synced_s;

`ifdef FLAPPY_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);
  logic [CNT_W-1:0] rcnt_r, rcnt_s;
  logic             rfirst_r, rfirst_s;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_W'(1);
    end
  endfunction

  assign synced_s = sync_r[SYNC_STAGES-1];

  // next-state logic for the debounce FSM and optional repeat counter
  always_comb begin
    state_s = state_r;
    cnt_s   = {CNT_W{1'b0}};
    level_s = level_r;
    press_s = 1'b0;
    rel_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (synced_s) begin
          state_s = ST_PRESS_CHK;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PRESS_CHK: begin
        if (!synced_s) begin
          state_s = ST_IDLE;
        end else if (cnt_r == DEB_LAST) begin
          state_s = ST_HELD;
          level_s = 1'b1;
          press_s = 1'b1;
        end else begin
          cnt_s = sat_inc(cnt_r);
        end
      end
      ST_HELD: begin
        if (!synced_s) begin
          state_s = ST_REL_CHK;
        end else begin
          state_s = ST_HELD;
        end
      end
      ST_REL_CHK: begin
        if (synced_s) begin
          state_s = ST_HELD;
        end else if (cnt_r == DEB_LAST) begin
          state_s = ST_IDLE;
          level_s = 1'b0;
          rel_s   = 1'b1;
        end else begin
          cnt_s = sat_inc(cnt_r);
        end
      end
      default: begin
        state_s = ST_IDLE;
        level_s = 1'b0;
      end
    endcase
`ifdef FLAPPY_AUTOREPEAT_EN
    rcnt_s   = {CNT_W{1'b0}};
    rfirst_s = 1'b1;
    // first repeat waits the delay, later ones the period
    if ((state_r == ST_HELD) && synced_s) begin
      if (rcnt_r == (rfirst_r ? RD_LAST : RP_LAST)) begin
        press_s  = 1'b1;
        rfirst_s = 1'b0;
      end else begin
        rcnt_s   = sat_inc(rcnt_r);
        rfirst_s = rfirst_r;
      end
    end else begin
      rcnt_s   = {CNT_W{1'b0}};
      rfirst_s = 1'b1;
    end
`endif
  end

  // state registers; clr (design disabled) idles the channel silently
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_r   <= {SYNC_STAGES{1'b0}};
      state_r  <= ST_IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      level_r  <= 1'b0;
      press_r  <= 1'b0;
      rel_r    <= 1'b0;
`ifdef FLAPPY_AUTOREPEAT_EN
      rcnt_r   <= {CNT_W{1'b0}};
      rfirst_r <= 1'b1;
`endif
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], din};
      if (clr) begin
        state_r  <= ST_IDLE;
        cnt_r    <= {CNT_W{1'b0}};
        level_r  <= 1'b0;
        press_r  <= 1'b0;
        rel_r    <= 1'b0;
`ifdef FLAPPY_AUTOREPEAT_EN
        rcnt_r   <= {CNT_W{1'b0}};
        rfirst_r <= 1'b1;
`endif
      end else begin
        state_r  <= state_s;
        cnt_r    <= cnt_s;
        level_r  <= level_s;
        press_r  <= press_s;
        rel_r    <= rel_s;
`ifdef FLAPPY_AUTOREPEAT_EN
        rcnt_r   <= rcnt_s;
        rfirst_r <= rfirst_s;
`endif
      end
    end
  end

  assign level = level_r;
  assign press = press_r;
  assign rel   = rel_r;

endmodule

// File: rtl/flappy_param_chk.sv
// Elaboration-time parameter checks for the button conditioner.
// Repeat-counter width is only checked when FLAPPY_AUTOREPEAT_EN is defined.
module flappy_param_chk #(
  parameter int N_BTN           = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1,
  parameter int CNT_W           = 16,
  parameter int REPEAT_DELAY    = 1,
  parameter int REPEAT_PERIOD   = 1
) ();

  if (N_BTN < 2) begin : g_nbtn_err
    $error("flappy: N_BTN must be at least 2");
  end
  if (SYNC_STAGES < 2) begin : g_sync_err
    $error("flappy: SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_deb_min_err
    $error("flappy: DEBOUNCE_CYCLES must be at least 1");
  end
  if (64'(DEBOUNCE_CYCLES) > (64'd1 << CNT_W)) begin : g_deb_w_err
    $error("flappy: CNT_W too narrow for DEBOUNCE_CYCLES");
  end
  if ((REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1)) begin : g_rep_min_err
    $error("flappy: repeat timing must be at least 1");
  end
`ifdef FLAPPY_AUTOREPEAT_EN
  if ((64'(REPEAT_DELAY) > (64'd1 << CNT_W)) ||
      (64'(REPEAT_PERIOD) > (64'd1 << CNT_W))) begin : g_rep_w_err
    $error("flappy: CNT_W too narrow for repeat timing");
  end
`endif

endmodule

// File: rtl/flappy_button_conditioner.sv
// Button conditioner top: ena gating, per-channel debounce, conflict flag.
// Optional auto-repeat is enabled by defining FLAPPY_AUTOREPEAT_EN.
module flappy_button_conditioner
  import flappy_pkg::*;
#(
  parameter int N_BTN           = DEF_N_BTN,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             btn_conflict
);

  logic [N_BTN-1:0] din_s;
  logic             clr_s;
  logic             conflict_r;

  assign din_s = btn_raw & {N_BTN{ena}};
  assign clr_s = ~ena;

  flappy_param_chk #(
    .N_BTN(N_BTN), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W(CNT_W), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_chk ();

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    flappy_debounce_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W(CNT_W)
`ifdef FLAPPY_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
`endif
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (clr_s),
      .din  (din_s[g]),
      .level(btn_level[g]),
      .press(btn_press[g]),
      .rel  (btn_release[g])
    );
  end

  // conflict flag lags btn_level by one cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      conflict_r <= 1'b0;
    end else if (!ena) begin
      conflict_r <= 1'b0;
    end else begin
      conflict_r <= btn_level[BTN_UP] & btn_level[BTN_DOWN];
    end
  end

  assign btn_conflict = conflict_r;

endmodule

// File: tb/tb_flappy_button_conditioner.sv
// Self-checking bench: directed button scenarios against a behavioural model
// (run-length debounce, held-age auto-repeat) plus hand-computed edge checks.
module tb_flappy_button_conditioner;

  localparam int S  = 2;
  localparam int D  = 4;
  localparam int RD = 8;
  localparam int RP = 4;

  logic       clk = 1'b0;
  logic       rst_n, ena;
  logic [1:0] btn_raw, btn_level, btn_press, btn_release;
  logic       btn_conflict;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // behavioural model state
  logic [S-1:0] sq_m [2];
  logic [1:0]   lvl_m, prs_m, rel_m;
  logic         cfl_m;
  int           run_m [2];
  int           age_m [2];

  flappy_button_conditioner #(
    .N_BTN(2), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .CNT_W(16),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .btn_conflict(btn_conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, exp);
    end
  endtask

  // A level flips once the synchronised input has disagreed with it for D+1
  // consecutive samples; held age counts stable held samples for repeats.
  task automatic model_edge(input logic [1:0] raw, input logic r, input logic e);
    logic       syn;
    logic [1:0] lvl_old;
    if (!r) begin
      for (int c = 0; c < 2; c++) begin
        sq_m[c] = '0; run_m[c] = 0; age_m[c] = 0;
      end
      lvl_m = 2'b00; prs_m = 2'b00; rel_m = 2'b00; cfl_m = 1'b0;
    end else begin
      cfl_m   = e & lvl_m[0] & lvl_m[1];
      lvl_old = lvl_m;
      for (int c = 0; c < 2; c++) begin
        syn = sq_m[c][S-1];
        sq_m[c] = {sq_m[c][S-2:0], raw[c] & e};
        prs_m[c] = 1'b0;
        rel_m[c] = 1'b0;
        if (!e) begin
          lvl_m[c] = 1'b0; run_m[c] = 0; age_m[c] = 0;
        end else begin
          if (lvl_old[c] && syn && run_m[c] == 0) age_m[c]++;
          else age_m[c] = 0;
`ifdef FLAPPY_AUTOREPEAT_EN
          if (age_m[c] >= RD && ((age_m[c] - RD) % RP) == 0) prs_m[c] = 1'b1;
`endif
          if (syn != lvl_old[c]) begin
            run_m[c]++;
            if (run_m[c] == D + 1) begin
              lvl_m[c] = syn;
              run_m[c] = 0;
              if (syn) prs_m[c] = 1'b1;
              else rel_m[c] = 1'b1;
            end
          end else begin
            run_m[c] = 0;
          end
        end
      end
    end
  endtask

  task automatic step(input logic [1:0] raw, input logic r, input logic e);
    btn_raw = raw; rst_n = r; ena = e;
    @(posedge clk);
    model_edge(raw, r, e);
    @(negedge clk);
    chk("level", btn_level, lvl_m);
    chk("press", btn_press, prs_m);
    chk("release", btn_release, rel_m);
    chk("conflict", {1'b0, btn_conflict}, {1'b0, cfl_m});
  endtask

  task automatic do_reset();
    step(2'b00, 1'b0, 1'b1);
    step(2'b00, 1'b0, 1'b1);
    chk("rst_level", btn_level, 2'b00);
    chk("rst_conflict", {1'b0, btn_conflict}, 2'b00);
  endtask

  initial begin
    logic [1:0] exp_rep;
    btn_raw = 2'b00; rst_n = 1'b0; ena = 1'b1;
    // clean press then release
    do_reset();
    for (int e = 0; e < 46; e++) begin
      cyc = e;
      step((e < 30) ? 2'b01 : 2'b00, 1'b1, 1'b1);
      if (e == 5)  chk("A_press5", btn_press, 2'b00);
      if (e == 6)  chk("A_press6", btn_press, 2'b01);
      if (e == 6)  chk("A_level6", btn_level, 2'b01);
      if (e == 7)  chk("A_press7_lvl", btn_level, 2'b01);
      if (e == 35) chk("A_level35", btn_level, 2'b01);
      if (e == 36) chk("A_rel36", btn_release, 2'b01);
      if (e == 36) chk("A_level36", btn_level, 2'b00);
      if (e == 37) chk("A_rel37", btn_release, 2'b00);
    end
    // short glitch
    do_reset();
    for (int e = 0; e < 15; e++) begin
      cyc = e;
      step((e < 3) ? 2'b01 : 2'b00, 1'b1, 1'b1);
      chk("B_glitch_level", btn_level, 2'b00);
      chk("B_glitch_press", btn_press, 2'b00);
    end
    // both buttons, down released first
    do_reset();
    for (int e = 0; e < 42; e++) begin
      cyc = e;
      step((e < 20) ? 2'b11 : ((e < 30) ? 2'b01 : 2'b00), 1'b1, 1'b1);
      if (e == 6)  chk("C_press6", btn_press, 2'b11);
      if (e == 6)  chk("C_conf6", {1'b0, btn_conflict}, 2'b00);
      if (e == 7)  chk("C_conf7", {1'b0, btn_conflict}, 2'b01);
      if (e == 26) chk("C_rel26", btn_release, 2'b10);
      if (e == 26) chk("C_conf26", {1'b0, btn_conflict}, 2'b01);
      if (e == 27) chk("C_conf27", {1'b0, btn_conflict}, 2'b00);
    end
    // reset in the middle of a press count
    do_reset();
    for (int e = 0; e < 16; e++) begin
      cyc = e;
      step(2'b01, (e != 4), 1'b1);
      if (e == 4)  chk("D_rst_level", btn_level, 2'b00);
      if (e == 6)  chk("D_press6", btn_press, 2'b00);
      if (e == 10) chk("D_press10", btn_press, 2'b00);
      if (e == 11) chk("D_press11", btn_press, 2'b01);
    end
    // long hold: auto-repeat pulses only when enabled
`ifdef FLAPPY_AUTOREPEAT_EN
    exp_rep = 2'b01;
`else
    exp_rep = 2'b00;
`endif
    do_reset();
    for (int e = 0; e < 48; e++) begin
      cyc = e;
      step((e < 40) ? 2'b01 : 2'b00, 1'b1, 1'b1);
      if (e == 6)  chk("E_press6", btn_press, 2'b01);
      if (e == 14) chk("E_press14", btn_press, exp_rep);
      if (e == 16) chk("E_press16", btn_press, 2'b00);
      if (e == 18) chk("E_press18", btn_press, exp_rep);
      if (e == 22) chk("E_press22", btn_press, exp_rep);
    end
    // ena dropped while held
    do_reset();
    for (int e = 0; e < 30; e++) begin
      cyc = e;
      step(2'b01, 1'b1, !(e >= 10 && e < 14));
      if (e == 9)  chk("F_level9", btn_level, 2'b01);
      if (e == 10) chk("F_level10", btn_level, 2'b00);
      if (e == 10) chk("F_rel10", btn_release, 2'b00);
      if (e == 19) chk("F_press19", btn_press, 2'b00);
      if (e == 20) chk("F_press20", btn_press, 2'b01);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
